// File: rtl/instruction_memory_sync.sv
// Synchronous instruction store: valid/ready fetch port with a registered 1-cycle
// response, plus a run-time load port. Misaligned/out-of-range fetches return a fault.
module instruction_memory_sync #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 32,
  parameter int                 ADDR_W    = 32,
  parameter logic [DATA_W-1:0]  INIT_WORD = 32'h00000013
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_fault,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int UP_LO = 2 + IDX_W;

  typedef struct packed {
    logic             oor;
    logic             misal;
    logic [IDX_W-1:0] idx;
  } dec_t;

  typedef struct packed {
    logic              fault;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Any bit above the index field is out of range, so aliased PCs fault instead of wrapping.
  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t d;
    d.oor   = (a >> UP_LO) != '0;
    d.misal = |a[1:0];
    d.idx   = a[2 +: IDX_W];
    return d;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  dec_t req_dec, wr_dec;
  rsp_t rsp_d, rsp_q;
  logic rsp_vld, accept, wr_hit;

  assign req_dec     = decode(i_req_addr);
  assign wr_dec      = decode(i_wr_addr);
  assign wr_hit      = i_wr_en && !wr_dec.oor;
  assign o_req_ready = !rsp_vld || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;

  // Write-first: a same-edge load to the fetched word is forwarded into the response.
  always_comb begin
    rsp_d = '0;
    if (req_dec.oor || req_dec.misal)
      rsp_d.fault = 1'b1;
    else if (wr_hit && wr_dec.idx == req_dec.idx)
      rsp_d.data = i_wr_data;
    else
      rsp_d.data = mem[req_dec.idx];
  end

  always_ff @(posedge i_clk) begin
    if (wr_hit) mem[wr_dec.idx] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_vld <= 1'b0;
      rsp_q   <= '0;
    end else if (accept) begin
      rsp_vld <= 1'b1;
      rsp_q   <= rsp_d;
    end else if (i_rsp_ready) begin
      rsp_vld <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_vld;
  assign o_rsp_data  = rsp_q.data;
  assign o_rsp_fault = rsp_q.fault;
endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed plan plus randomized traffic, checked cycle by cycle against a
// word-array / response-slot reference model.
module tb_instruction_memory_sync;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_fault;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;

  instruction_memory_sync #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_WORD(32'h00000013)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_fault(o_rsp_fault),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [ADDR_W-1:0] a);
    return a < DEPTH * 4;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance model, take the edge.
  task automatic cycle(input logic vld, input logic [ADDR_W-1:0] addr, input logic rr,
                       input logic we, input logic [ADDR_W-1:0] waddr,
                       input logic [DATA_W-1:0] wdata);
    bit acc;
    i_req_valid = vld; i_req_addr = addr; i_rsp_ready = rr;
    i_wr_en = we; i_wr_addr = waddr; i_wr_data = wdata;
    #3;
    chk("req_ready", 32'(o_req_ready), 32'(!m_valid || rr));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_data",  o_rsp_data, m_data);
      chk("rsp_fault", 32'(o_rsp_fault), 32'(m_fault));
    end
    acc = vld && (!m_valid || rr);
    if (we && in_range(waddr)) m_mem[waddr / 4] = wdata;
    if (acc) begin
      m_valid = 1'b1;
      if (addr % 4 != 0 || !in_range(addr)) begin
        m_fault = 1'b1; m_data = '0;
      end else begin
        m_fault = 1'b0; m_data = m_mem[addr / 4];
      end
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] addr, input logic rr);
    cycle(1'b1, addr, rr, 1'b0, '0, '0);
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, '0, rr, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h00000013;
    m_valid = 1'b0; m_data = '0; m_fault = 1'b0;
    i_rst = 1'b1; i_req_valid = 0; i_req_addr = '0; i_rsp_ready = 0;
    i_wr_en = 0; i_wr_addr = '0; i_wr_data = '0;
    #1;
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_data",  o_rsp_data, 32'd0);
    chk("rst_fault", 32'(o_rsp_fault), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // 1: back-to-back NOP fetches
    fetch(32'h0, 1); fetch(32'h4, 1); fetch(32'h8, 1); idle(1); idle(1);
    // 2: load then fetch
    cycle(0, '0, 1, 1, 32'h0,  32'h02328020);
    cycle(0, '0, 1, 1, 32'h7C, 32'h00A00093);
    fetch(32'h7C, 1); fetch(32'h0, 1); idle(1);
    chk("load_0x7c", m_mem[31], 32'h00A00093);
    // 3: stall holds, pending request waits for ready
    fetch(32'h0, 1);
    for (int i = 0; i < 3; i++) fetch(32'h4, 0);
    fetch(32'h4, 1); idle(1); idle(1);
    // 4: faults and dropped out-of-range write
    fetch(32'h2, 1); fetch(32'h80, 1); idle(1);
    cycle(0, '0, 1, 1, 32'h80, 32'hFFFFFFFF);
    fetch(32'h0, 1); idle(1);
    // 5: write-first on same edge, other word unaffected
    cycle(1, 32'h10, 1, 1, 32'h10, 32'hDEADBEEF); idle(1);
    cycle(1, 32'h14, 1, 1, 32'h18, 32'hCAFEF00D); fetch(32'h18, 1); idle(1);
    // write into the word held by a stalled response must not disturb it
    fetch(32'h18, 1);
    cycle(0, '0, 0, 1, 32'h18, 32'h12345678);
    idle(0); idle(1); fetch(32'h18, 1); idle(1);

    // 6: async reset during a stall
    fetch(32'h0, 1);
    i_req_valid = 0; i_rsp_ready = 0;
    #3;
    chk("stall_valid", 32'(o_rsp_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_rsp_valid), 32'd0);
    chk("arst_data",  o_rsp_data, 32'd0);
    chk("arst_fault", 32'(o_rsp_fault), 32'd0);
    m_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    fetch(32'h0, 1); idle(1);
    chk("post_rst_mem0", m_mem[0], 32'h02328020);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] ra, wa;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)      ra = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel < 8) ra = 32'($urandom_range(0, DEPTH * 4 - 1));
      else if (sel < 9) ra = 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 64));
      else              ra = $urandom;
      wa = ($urandom_range(0, 7) == 0) ? $urandom
                                      : 32'($urandom_range(0, DEPTH * 4 - 1));
      cycle(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), wa, $urandom);
    end
    idle(1); idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
